// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// riscv_pkg
// Shared opcode encoding, decoded-bundle type and immediate helper for the
// 16-bit instruction decode path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  // Seven defined opcodes; 3'b111 is deliberately left undefined (illegal).
  typedef enum logic [2:0] {
    R_OP  = 3'd0,
    I_OP  = 3'd1,
    L_OP  = 3'd2,
    S_OP  = 3'd3,
    B_OP  = 3'd4,
    J_OP  = 3'd5,
    JR_OP = 3'd6
  } opcode_t;

  localparam int XLEN_DEF   = 16;
  localparam int REG_AW_DEF = 3;
  // Widest immediate the sign-extension helper can produce.
  localparam int SEXT_MAX   = 64;

  // Decoded bundle at the default widths.
  typedef struct packed {
    opcode_t                 opcode;
    logic [REG_AW_DEF-1:0]   rd;
    logic [REG_AW_DEF-1:0]   rs1;
    logic [REG_AW_DEF-1:0]   rs2;
    logic [3:0]              func4;
    logic [2:0]              func2;
    logic [XLEN_DEF-1:0]     imm;
    logic                    rd_we;
    logic                    illegal;
  } decoded_t;

  // Sign-extend the low 'width' bits of val (width 1..16) to SEXT_MAX bits.
  function automatic logic [SEXT_MAX-1:0] sext_imm(input logic [15:0] val,
                                                   input int width);
    logic [SEXT_MAX-1:0] r;
    logic [3:0]          msb;
    msb = 4'(width - 1);
    r   = '0;
    for (int i = 0; i < SEXT_MAX; i++) begin
      if (i < width) r[i] = val[i[3:0]];
      else           r[i] = val[msb];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_fields.sv
//------------------------------------------------------------------------------
// decode_fields
// Combinational field extraction, immediate sign extension, source-usage
// flags and illegal-opcode detection for one 16-bit instruction word.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_fields
  import riscv_pkg::*;
#(
  parameter int XLEN   = 16,
  parameter int REG_AW = 3
) (
  input  logic [15:0]       instr,
  output logic [2:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [3:0]        func4,
  output logic [2:0]        func2,
  output logic [XLEN-1:0]   imm,
  output logic              rd_we,
  output logic              illegal,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  // Raw 3-bit register fields, zero-extended to the register address width.
  logic [REG_AW-1:0] w_f53;
  logic [REG_AW-1:0] w_f86;
  logic [REG_AW-1:0] w_f119;
  logic [XLEN-1:0]   w_imm4;
  logic [XLEN-1:0]   w_imm10;
  logic [XLEN-1:0]   w_imm6;
  logic              w_writes;

  assign w_f53   = REG_AW'(instr[5:3]);
  assign w_f86   = REG_AW'(instr[8:6]);
  assign w_f119  = REG_AW'(instr[11:9]);
  assign w_imm4  = XLEN'(sext_imm(16'(instr[15:12]), 4));
  assign w_imm10 = XLEN'(sext_imm(16'(instr[15:6]), 10));
  assign w_imm6  = XLEN'(sext_imm(16'(instr[15:10]), 6));

  // Per-format field selection; anything a format does not use stays zero.
  always_comb begin
    opcode   = instr[2:0];
    rd       = '0;
    rs1      = '0;
    rs2      = '0;
    func4    = '0;
    func2    = '0;
    imm      = '0;
    w_writes = 1'b0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_t'(instr[2:0]))
      R_OP: begin
        rd = w_f53; rs1 = w_f86; rs2 = w_f119; func4 = instr[15:12];
        w_writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      I_OP, L_OP: begin
        rd = w_f53; rs1 = w_f86; func2 = instr[11:9]; imm = w_imm4;
        w_writes = 1'b1; uses_rs1 = 1'b1;
      end
      S_OP, B_OP: begin
        rs1 = w_f86; rs2 = w_f53; func2 = instr[11:9]; imm = w_imm4;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      J_OP: begin
        rd = w_f53; imm = w_imm10; w_writes = 1'b1;
      end
      JR_OP: begin
        rd = w_f53; rs1 = w_f86; imm = w_imm6;
        w_writes = 1'b1; uses_rs1 = 1'b1;
      end
      // Undefined opcode: flag it, keep the raw opcode visible, zero the rest.
      default: illegal = 1'b1;
    endcase
  end

  // Register 0 is hardwired zero, so writing it is never a real write.
  assign rd_we = w_writes && (rd != '0);

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage
// Registered decode stage between fetch and execute: valid/ready handshake,
// load-use hazard stalling, flush, and a saturating stall-cycle counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [15:0]       instr_i,
  input  logic              ex_load_valid_i,
  input  logic [REG_AW-1:0] ex_load_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2:0]        opcode_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [3:0]        func4_o,
  output logic [2:0]        func2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              rd_we_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [2:0]        w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [3:0]        w_func4;
  logic [2:0]        w_func2;
  logic [XLEN-1:0]   w_imm;
  logic              w_rd_we;
  logic              w_illegal;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_hazard;
  logic              w_transfer;

  logic              r_valid;
  logic [2:0]        r_opcode;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [3:0]        r_func4;
  logic [2:0]        r_func2;
  logic [XLEN-1:0]   r_imm;
  logic              r_rd_we;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  decode_fields #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fields (
    .instr    (instr_i),
    .opcode   (w_opcode),
    .rd       (w_rd),
    .rs1      (w_rs1),
    .rs2      (w_rs2),
    .func4    (w_func4),
    .func2    (w_func2),
    .imm      (w_imm),
    .rd_we    (w_rd_we),
    .illegal  (w_illegal),
    .uses_rs1 (w_uses_rs1),
    .uses_rs2 (w_uses_rs2)
  );

  // Incoming instruction reads a register the load in execute has not produced.
  assign w_hazard = in_valid_i && ex_load_valid_i && (ex_load_rd_i != '0) &&
                    ((w_uses_rs1 && (w_rs1 == ex_load_rd_i)) ||
                     (w_uses_rs2 && (w_rs2 == ex_load_rd_i)));

  assign in_ready_o = !w_hazard && (!r_valid || out_ready_i);
  // Flush suppresses capture even though in_ready_o is still reported.
  assign w_transfer = in_valid_i && in_ready_o && !flush_i;

  // Output bundle register: flush drops, transfer loads, consumption bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_func4   <= '0;
      r_func2   <= '0;
      r_imm     <= '0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_transfer) begin
      r_valid   <= 1'b1;
      r_opcode  <= w_opcode;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_func4   <= w_func4;
      r_func2   <= w_func2;
      r_imm     <= w_imm;
      r_rd_we   <= w_rd_we;
      r_illegal <= w_illegal;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use hazards (flush cycles excluded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_hazard && !flush_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid_o = r_valid;
  assign opcode_o    = r_opcode;
  assign rd_o        = r_rd;
  assign rs1_addr_o  = r_rs1;
  assign rs2_addr_o  = r_rs2;
  assign func4_o     = r_func4;
  assign func2_o     = r_func2;
  assign imm_o       = r_imm;
  assign rd_we_o     = r_rd_we;
  assign illegal_o   = r_illegal;
  assign stall_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// tb_decode_stage
// Scoreboard bench for decode_stage (XLEN=32, REG_AW=3, CNT_W=4).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
  import riscv_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [15:0]       instr_i = '0;
  logic              ex_load_valid_i = 1'b0;
  logic [REG_AW-1:0] ex_load_rd_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [2:0]        opcode_o;
  logic [REG_AW-1:0] rd_o, rs1_addr_o, rs2_addr_o;
  logic [3:0]        func4_o;
  logic [2:0]        func2_o;
  logic [XLEN-1:0]   imm_o;
  logic              rd_we_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instr_i(instr_i),
    .ex_load_valid_i(ex_load_valid_i), .ex_load_rd_i(ex_load_rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .opcode_o(opcode_o), .rd_o(rd_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .func4_o(func4_o), .func2_o(func2_o),
    .imm_o(imm_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op, rd, rs1, rs2, f4, f2;
    logic [31:0] imm;
    bit          we, ill, u1, u2;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  bit   mvalid = 0;
  int   mcnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Two's-complement value of the low 'bits' bits of v, widened to 32 bits.
  function automatic logic [31:0] sx(input int v, input int bits);
    int r;
    r = v;
    if (v >= (1 << (bits - 1))) r = v - (1 << bits);
    return 32'(r);
  endfunction

  // Reference decode written directly from the instruction-format rules.
  function automatic exp_t ref_decode(input logic [15:0] ins);
    exp_t e;
    int w, a, b, c, t4;
    w  = int'(ins);
    a  = (w / 8) % 8;
    b  = (w / 64) % 8;
    c  = (w / 512) % 8;
    t4 = w / 4096;
    e = '{op: w % 8, rd: 0, rs1: 0, rs2: 0, f4: 0, f2: 0, imm: 32'd0,
          we: 0, ill: 0, u1: 0, u2: 0};
    if (e.op == int'(R_OP)) begin
      e.rd = a; e.rs1 = b; e.rs2 = c; e.f4 = t4; e.u1 = 1; e.u2 = 1;
    end else if (e.op == int'(I_OP) || e.op == int'(L_OP)) begin
      e.rd = a; e.rs1 = b; e.f2 = c; e.imm = sx(t4, 4); e.u1 = 1;
    end else if (e.op == int'(S_OP) || e.op == int'(B_OP)) begin
      e.rs1 = b; e.rs2 = a; e.f2 = c; e.imm = sx(t4, 4); e.u1 = 1; e.u2 = 1;
    end else if (e.op == int'(J_OP)) begin
      e.rd = a; e.imm = sx(w / 64, 10);
    end else if (e.op == int'(JR_OP)) begin
      e.rd = a; e.rs1 = b; e.imm = sx(w / 1024, 6); e.u1 = 1;
    end else begin
      e.ill = 1;
    end
    e.we = !e.ill && e.op != int'(S_OP) && e.op != int'(B_OP) && e.rd != 0;
    return e;
  endfunction

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit inv, input logic [15:0] ins, input bit lv,
                       input int lrd, input bit ordy, input bit fl);
    exp_t e;
    bit   hz, er;
    check("out_valid", 64'(out_valid_o), 64'(mvalid));
    check("stall_cnt", 64'(stall_cnt_o), 64'(mcnt));
    if (mvalid && expq.size() > 0) begin
      check("held_rd",  64'(rd_o),  64'(expq[0].rd));
      check("held_imm", 64'(imm_o), 64'(expq[0].imm));
    end
    in_valid_i = inv; instr_i = ins; ex_load_valid_i = lv;
    ex_load_rd_i = REG_AW'(lrd); out_ready_i = ordy; flush_i = fl;
    e  = ref_decode(ins);
    hz = inv && lv && lrd != 0 && ((e.u1 && e.rs1 == lrd) || (e.u2 && e.rs2 == lrd));
    er = !hz && (!mvalid || ordy);
    #1;
    check("in_ready", 64'(in_ready_o), 64'(er));
    if (hz && !fl && mcnt < (1 << CNT_W) - 1) mcnt++;
    if (fl) begin
      if (mvalid && !ordy) void'(expq.pop_front());
      mvalid = 0;
    end else if (inv && er) begin
      expq.push_back(e);
      mvalid = 1;
    end else if (ordy) begin
      mvalid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every bundle the execute stage actually takes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_o && out_ready_i) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 64'(out_valid_o), 64'(0));
        end else begin
          e = expq.pop_front();
          check("opcode", 64'(opcode_o),   64'(e.op));
          check("rd",     64'(rd_o),       64'(e.rd));
          check("rs1",    64'(rs1_addr_o), 64'(e.rs1));
          check("rs2",    64'(rs2_addr_o), 64'(e.rs2));
          check("func4",  64'(func4_o),    64'(e.f4));
          check("func2",  64'(func2_o),    64'(e.f2));
          check("imm",    64'(imm_o),      64'(e.imm));
          check("rd_we",  64'(rd_we_o),    64'(e.we));
          check("illegal",64'(illegal_o),  64'(e.ill));
        end
      end
    end
  end

  task automatic random_cycles(input int n);
    logic [15:0] ins;
    int          lrd;
    for (int i = 0; i < n; i++) begin
      ins = 16'($urandom);
      lrd = ($urandom_range(0, 1) == 1) ? int'(ins[8:6]) : $urandom_range(0, 7);
      cycle($urandom_range(0, 9) < 7, ins, $urandom_range(0, 1) == 1, lrd,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_imm",       64'(imm_o),       64'(0));
    check("rst_stall",     64'(stall_cnt_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;

    // I_OP rd=2 rs1=1 func2=0 imm=1110 -> imm FFFFFFFE
    cycle(1, {4'b1110, 3'd0, 3'd1, 3'd2, 3'(I_OP)}, 0, 0, 1, 0);
    check("i_imm", 64'(imm_o), 64'hFFFF_FFFE);
    check("i_rd",  64'(rd_o),  64'd2);
    check("i_rs1", 64'(rs1_addr_o), 64'd1);
    // J_OP imm10=0x200, rd=3
    cycle(1, {10'h200, 3'd3, 3'(J_OP)}, 0, 0, 1, 0);
    check("j_imm", 64'(imm_o), 64'hFFFF_FE00);
    check("j_we",  64'(rd_we_o), 64'd1);
    // JR_OP imm6=0x3F
    cycle(1, {6'h3F, 1'b0, 3'd4, 3'd5, 3'(JR_OP)}, 0, 0, 1, 0);
    check("jr_imm", 64'(imm_o), 64'hFFFF_FFFF);
    // undefined opcode
    cycle(1, 16'hFFFF, 0, 0, 1, 0);
    check("ill_flag", 64'(illegal_o), 64'd1);
    check("ill_imm",  64'(imm_o),     64'd0);
    check("ill_rd",   64'(rd_o),      64'd0);
    check("ill_we",   64'(rd_we_o),   64'd0);
    // load-use hazard on rs2=3 for two cycles, then the load leaves
    cycle(1, {4'd0, 3'd3, 3'd1, 3'd2, 3'(R_OP)}, 1, 3, 1, 0);
    cycle(1, {4'd0, 3'd3, 3'd1, 3'd2, 3'(R_OP)}, 1, 3, 1, 0);
    check("hz_cnt", 64'(stall_cnt_o), 64'd2);
    cycle(1, {4'd0, 3'd3, 3'd1, 3'd2, 3'(R_OP)}, 1, 0, 1, 0);
    // back-to-back stream with 3 cycles of backpressure
    for (int i = 0; i < 3; i++) cycle(1, {4'(i), 3'd1, 3'd2, 3'd3, 3'(I_OP)}, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, {4'(i + 8), 3'd1, 3'd2, 3'd4, 3'(L_OP)}, 0, 0, 1, 0);
    // flush with a held bundle and a valid input
    cycle(1, {4'd5, 3'd0, 3'd1, 3'd6, 3'(I_OP)}, 0, 0, 0, 1);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    cycle(1, {4'd5, 3'd0, 3'd1, 3'd6, 3'(I_OP)}, 0, 0, 1, 0);
    cycle(1, {4'd7, 3'd0, 3'd1, 3'd6, 3'(I_OP)}, 0, 0, 1, 1);

    random_cycles(1500);

    // asynchronous reset in the middle of traffic
    cycle(1, {4'd3, 3'd0, 3'd1, 3'd6, 3'(I_OP)}, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_rd",    64'(rd_o),        64'd0);
    check("arst_imm",   64'(imm_o),       64'd0);
    check("arst_cnt",   64'(stall_cnt_o), 64'd0);
    expq.delete();
    mvalid = 0;
    mcnt = 0;
    in_valid_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // saturation: far more than 2^CNT_W hazard cycles
    for (int i = 0; i < (1 << CNT_W) + 5; i++)
      cycle(1, {4'd0, 3'd2, 3'd5, 3'd1, 3'(R_OP)}, 1, 5, 1, 0);
    check("sat_cnt", 64'(stall_cnt_o), 64'hF);

    random_cycles(500);
    cycle(0, 16'h0, 0, 0, 1, 0);
    cycle(0, 16'h0, 0, 0, 1, 0);
    check("drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
